// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream/downstream valid-ready channels plus flush
// and occupancy. The slave modport is the stage side; master is the driver/observer side.
interface pipe_stage_reg_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       level;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register. Define PIPE_STAGE_SKID_EN for the two-entry skid variant with
// fully registered in_ready; otherwise a single-entry stage with combinational in_ready.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic             clk,
   input logic             reset,
   pipe_stage_reg_if.slave bus
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             out_valid_q;
   logic             in_xfer;
   logic             out_xfer;

   assign out_xfer      = out_valid_q && bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;

   always_comb begin
      bus.level = 2'd0;
      unique case (state_q)
         StEmpty: bus.level = 2'd0;
         StOne:   bus.level = 2'd1;
         StTwo:   bus.level = 2'd2;
         default: bus.level = 2'd0;
      endcase
   end

`ifdef PIPE_STAGE_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q;

   assign bus.in_ready = in_ready_q;
   assign in_xfer      = bus.in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         state_d = StEmpty;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_d = StOne;
                  main_d  = bus.in_data;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  main_d = bus.in_data;
               end else if (in_xfer) begin
                  state_d = StTwo;
                  skid_d  = bus.in_data;
               end else if (out_xfer) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_xfer) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StEmpty;
         main_q      <= RESET_VAL;
         skid_q      <= RESET_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         // Handshake flags mirror the next state so neither depends on this cycle's inputs.
         out_valid_q <= (state_d != StEmpty);
         in_ready_q  <= (state_d != StTwo);
      end
   end
`else
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign in_xfer      = bus.in_valid && bus.in_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (bus.flush) begin
         state_d = StEmpty;
         main_d  = RESET_VAL;
      end else if (in_xfer) begin
         state_d = StOne;
         main_d  = bus.in_data;
      end else if (out_xfer) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StEmpty;
         main_q      <= RESET_VAL;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         out_valid_q <= (state_d != StEmpty);
      end
   end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits): value loaded into every payload register on reset or flush.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port flush  input  1: synchronous pipeline clear.
REQ-006 Port in_valid  input  1: upstream payload valid.
REQ-007 Port in_ready  output  1: stage can accept a payload this cycle.
REQ-008 Port in_data  input  WIDTH: upstream payload.
REQ-009 Port out_valid  output  1: downstream payload valid.
REQ-010 Port out_ready  input  1: downstream accepts the payload this cycle.
REQ-011 Port out_data  output  WIDTH: downstream payload.
REQ-012 Port level  output  2: number of payloads held (0..2).

Function
REQ-013 An input transfer shall occur when in_valid and in_ready are both 1 at a clock edge; an output transfer shall occur when out_valid and out_ready are both 1.
REQ-014 The stage shall hold payloads in a main register (drives out_data) and a skid register, and shall use states EMPTY (level 0), ONE (level 1) and TWO (level 2).
REQ-015 EMPTY + input transfer -> ONE, with main loaded from in_data; in EMPTY, out_valid shall be 0 and out_ready shall be ignored.
REQ-016 ONE + input and output transfers -> ONE, with main loaded from in_data.
REQ-017 ONE + input transfer only -> TWO, with skid loaded from in_data and main held.
REQ-018 ONE + output transfer only -> EMPTY.
REQ-019 TWO + output transfer -> ONE, with main loaded from skid; in TWO no input transfer is possible.
REQ-020 With no transfer, state and payload registers shall hold.
REQ-021 out_valid shall equal (state != EMPTY); in_ready shall equal (state != TWO); both shall be driven directly from registers, with no combinational path from out_ready or in_valid.
REQ-022 Latency: a payload accepted at edge N shall appear on out_data after edge N if the stage was empty, and after the edge at which all older payloads have transferred out otherwise.
REQ-023 Ordering: payloads shall leave in strict acceptance order, with no loss or duplication.
REQ-024 flush=1 at an edge shall force EMPTY and load RESET_VAL into main and skid.
REQ-025 flush shall take priority over any simultaneous input or output transfer; an input offered on a flush cycle shall be discarded.
REQ-026 out_data shall hold its last value while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset=1 (asynchronous): state shall be EMPTY, main and skid shall be RESET_VAL, out_valid shall be 0, in_ready shall be 1 and level shall be 0.
REQ-028 Reset asserted mid-transfer shall discard all held payloads.
REQ-029 The first input transfer shall be possible at the first clock edge after reset deasserts.

Configuration
REQ-030 With macro PIPE_STAGE_SKID_EN defined, the stage shall implement the two-entry skid behaviour of REQ-014..REQ-021.
REQ-031 Without PIPE_STAGE_SKID_EN, the skid register and state TWO shall be omitted, and in_ready shall be combinational: (!out_valid || out_ready).
REQ-032 Without PIPE_STAGE_SKID_EN, an input transfer shall load main, the state shall be EMPTY/ONE only, and level shall be at most 1.
REQ-033 Without PIPE_STAGE_SKID_EN, flush and reset behaviour shall be unchanged.

Verification
REQ-034 Reset, then in_data=0xA5A5A5A5 valid for 1 cycle with out_ready=1 -> out_valid=1 and out_data=0xA5A5A5A5 on the next cycle, then out_valid=0.
REQ-035 out_ready=0, offer 0x1 then 0x2 -> level=2, in_ready=0; offer 0x3 (held) -> not accepted; out_ready=1 -> outputs 0x1, 0x2, 0x3 in order.
REQ-036 Level 2 with flush=1 and in_valid=1 (0x9) -> next cycle level=0, out_valid=0, out_data=RESET_VAL; 0x9 never appears.
REQ-037 Continuous in_valid=1 with out_ready=1 -> one transfer per cycle, level stays 1, sequence 0..99 emitted intact.
REQ-038 Random in_valid/out_ready for 10k cycles vs. a reference queue -> no loss, duplication or reordering; level <= 2 (<= 1 without PIPE_STAGE_SKID_EN).
REQ-039 reset asserted asynchronously between edges at level 2 -> out_valid=0 and level=0 immediately, before the next edge.
